// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable PAT_LEN-bit pattern, optional
// overlapping matches, a din_valid strobe and a saturating match counter.
module seq_detector_param #(
  parameter int PAT_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               pat_load,
  input  logic               overlap_en,
  input  logic               cnt_clr,
  output logic               flag,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // Alternating 1010... with the MSB (oldest bit) set to 1.
  function automatic logic [PAT_LEN-1:0] reset_pattern();
    logic [PAT_LEN-1:0] p;
    for (int i = 0; i < PAT_LEN; i++) begin
      p[i] = ((i % 2) == ((PAT_LEN - 1) % 2));
    end
    return p;
  endfunction

  localparam logic [PAT_LEN-1:0] PAT_RESET = reset_pattern();

  typedef enum logic {
    SEARCH = 1'b0,
    ARMED  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               flag_q, flag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic [PAT_LEN-1:0] hist_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic               match;

  assign hist_shift = {hist_q[PAT_LEN-2:0], din};
  assign fill_inc   = (state_q == ARMED) ? FILL_FULL : fill_q + FILL_W'(1);
  assign match      = din_valid && !pat_load && (fill_inc == FILL_FULL) &&
                      (hist_shift == pat_q);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    flag_d  = match;
    cnt_d   = cnt_q;
    sat_d   = sat_q;

    if (pat_load) begin
      pat_d   = pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = SEARCH;
    end else if (din_valid) begin
      hist_d = hist_shift;
      if (match && !overlap_en) begin
        // Non-overlapping: the next match must be built from fresh bits.
        fill_d  = '0;
        state_d = SEARCH;
      end else begin
        fill_d  = fill_inc;
        state_d = (fill_inc == FILL_FULL) ? ARMED : SEARCH;
      end
    end

    if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_d == CNT_MAX) begin
      sat_d = 1'b1;
    end
    // Clear wins over a same-cycle increment; flag is unaffected.
    if (cnt_clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEARCH;
      pat_q   <= PAT_RESET;
      hist_q  <= '0;
      fill_q  <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign flag      = flag_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule
